trigger_cfg_slave: RTL and testbench
====================================

// Module: trigger_cfg_slave
// PURPOSE
//  Write-only system-bus responder holding the trigger configuration: accepts
//  wvalid/wready/waddr/wdata transfers from the bus master into shadow registers.
//  A commit copies shadow to active outputs only while the trigger core is idle.
//  Sits between the bus master and the trigger matchers/counters.
// PARAMETERS
//  BAW  8   bus address width
//  BDW  32  bus data width
//  SDW  32  sample data width (matcher value/mask width, SDW<=BDW)
//  TMN  4   trigger matcher number
//  TCN  4   trigger counter number
//  TCW  32  counter reload width (TCW<=BDW)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        reset, asynchronous, active-low
//  bus_wready   out  1        responder ready
//  bus_wvalid   in   1        master write valid
//  bus_waddr    in   BAW      write address (word index)
//  bus_wdata    in   BDW      write data
//  trg_busy     in   1        trigger core running; commit is deferred while high
//  cfg_enable   out  1        trigger enable (direct, not shadowed)
//  cfg_mat_val  out  TMN*SDW  active matcher values, matcher i at [i*SDW+:SDW]
//  cfg_mat_msk  out  TMN*SDW  active matcher masks
//  cfg_cnt_rld  out  TCN*TCW  active counter reload values
//  cfg_update   out  1        one-cycle pulse after active set changes
//  err_cnt      out  8        count of writes to unmapped addresses, saturating
// BEHAVIOUR
//  - Transfer occurs on a rising clk edge with bus_wvalid && bus_wready.
//  - Address map: 0x00 CTRL (bit0 enable, bit1 commit, self-clearing);
//    0x04+2*i matcher i value, 0x05+2*i matcher i mask (i<TMN);
//    0x04+2*TMN+j counter j reload (j<TCN); data truncated to SDW/TCW LSBs.
//  - Unmapped address: transfer accepted, data dropped, err_cnt+1 (sticks at 255).
//  - Shadow writes take effect on the transfer edge; one write per cycle max.
//  - CTRL write: cfg_enable <= wdata[0] on the transfer edge, regardless of busy.
//  - States: IDLE, PEND. bus_wready = registered; 0 in reset, 1 from first edge
//    after reset release, 0 while in PEND.
//  - IDLE, CTRL write with bit1=1 and trg_busy=0: active <= shadow on same edge,
//    cfg_update high the following cycle, stay IDLE.
//  - IDLE, CTRL write with bit1=1 and trg_busy=1: go PEND, bus_wready drops next
//    cycle.
//  - PEND: on first edge sampling trg_busy=0, active <= shadow, cfg_update
//    pulse, return IDLE, bus_wready=1 again.
//  - Commit with bit0=0 both disables and commits in one transfer.
//  - Repeat commit while IDLE with no shadow change still pulses cfg_update.
//  - Reset (any time, incl. PEND): all shadow/active regs, cfg_enable, cfg_update,
//    err_cnt, bus_wready = 0; state IDLE; pending commit discarded.
//  - No combinational path from bus inputs to any output.
// TESTING
//  - Reset release: wready 0 during reset, 1 one cycle after; all cfg outputs 0.
//  - Write 0x04=0x76543210, 0x05=0x0000FFFF, 0x00=0x3, busy=0 -> mat_val[0]=
//    0x76543210, mat_msk[0]=0xFFFF, cfg_enable=1, one cfg_update pulse.
//  - Shadow write 0x0C=100 without commit -> cnt_rld[0] remains 0; after
//    commit -> 100.
//  - busy=1, commit -> wready low, outputs hold; drop busy after 5 cycles ->
//    update on that edge, cfg_update pulse, wready returns 1.
//  - 3 writes to 0xF0 -> err_cnt=3, no cfg change; 300 such writes -> 255.
//  - Assert rst while PEND -> all outputs 0, no later cfg_update.

Source files
------------

// File: rtl/trigger_cfg_slave_if.sv
// Write-only system bus between the bus master and the trigger configuration responder.
interface trigger_cfg_slave_if #(
    parameter int unsigned BAW = 8,
    parameter int unsigned BDW = 32
);
    logic           wvalid;
    logic           wready;
    logic [BAW-1:0] waddr;
    logic [BDW-1:0] wdata;

    modport master (output wvalid, output waddr, output wdata, input wready);
    modport slave  (input wvalid, input waddr, input wdata, output wready);
endinterface

// File: rtl/trigger_cfg_slave.sv
// Trigger configuration responder: bus writes land in shadow registers, and a commit
// copies shadow to the active outputs once the trigger core is idle.
module trigger_cfg_slave #(
    parameter int unsigned BAW = 8,
    parameter int unsigned BDW = 32,
    parameter int unsigned SDW = 32,
    parameter int unsigned TMN = 4,
    parameter int unsigned TCN = 4,
    parameter int unsigned TCW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    trigger_cfg_slave_if.slave   bus,
    input  logic                 trg_busy,
    output logic                 cfg_enable,
    output logic [TMN*SDW-1:0]   cfg_mat_val,
    output logic [TMN*SDW-1:0]   cfg_mat_msk,
    output logic [TCN*TCW-1:0]   cfg_cnt_rld,
    output logic                 cfg_update,
    output logic [7:0]           err_cnt
);

    localparam int unsigned RLD_BASE = 4 + 2 * TMN;

    typedef enum logic {IDLE, PEND} state_t;

    state_t               state_q, state_d;
    logic                 wready_q;
    logic                 enable_q;
    logic                 update_q;
    logic [7:0]           err_q;
    logic [TMN*SDW-1:0]   shd_val_q, shd_msk_q, act_val_q, act_msk_q;
    logic [TCN*TCW-1:0]   shd_rld_q, act_rld_q;

    logic                 xfer_c;
    logic                 ctrl_hit_c;
    logic [TMN-1:0]       val_hit_c, msk_hit_c;
    logic [TCN-1:0]       rld_hit_c;
    logic                 mapped_c;
    logic                 commit_req_c;
    logic                 do_commit_c;

    // Address decode of the current transfer
    always_comb begin
        xfer_c     = bus.wvalid & wready_q;
        ctrl_hit_c = (bus.waddr == BAW'(0));
        val_hit_c  = '0;
        msk_hit_c  = '0;
        rld_hit_c  = '0;
        for (int unsigned i = 0; i < TMN; i++) begin
            val_hit_c[i] = (bus.waddr == BAW'(4 + 2 * i));
            msk_hit_c[i] = (bus.waddr == BAW'(5 + 2 * i));
        end
        for (int unsigned j = 0; j < TCN; j++) begin
            rld_hit_c[j] = (bus.waddr == BAW'(RLD_BASE + j));
        end
        mapped_c     = ctrl_hit_c | (|val_hit_c) | (|msk_hit_c) | (|rld_hit_c);
        commit_req_c = xfer_c & ctrl_hit_c & bus.wdata[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Commit sequencing: immediate when idle, otherwise parked in PEND until busy drops
    always_comb begin
        state_d     = state_q;
        do_commit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_req_c) begin
                    if (trg_busy) state_d     = PEND;
                    else          do_commit_c = 1'b1;
                end
            end
            PEND: begin
                if (!trg_busy) begin
                    do_commit_c = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wready_q  <= 1'b0;
            enable_q  <= 1'b0;
            update_q  <= 1'b0;
            err_q     <= 8'd0;
            shd_val_q <= '0;
            shd_msk_q <= '0;
            shd_rld_q <= '0;
            act_val_q <= '0;
            act_msk_q <= '0;
            act_rld_q <= '0;
        end else begin
            if (xfer_c) begin
                if (ctrl_hit_c) enable_q <= bus.wdata[0];
                for (int unsigned i = 0; i < TMN; i++) begin
                    if (val_hit_c[i]) shd_val_q[i*SDW +: SDW] <= bus.wdata[SDW-1:0];
                    if (msk_hit_c[i]) shd_msk_q[i*SDW +: SDW] <= bus.wdata[SDW-1:0];
                end
                for (int unsigned j = 0; j < TCN; j++) begin
                    if (rld_hit_c[j]) shd_rld_q[j*TCW +: TCW] <= bus.wdata[TCW-1:0];
                end
                if (!mapped_c && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
            end
            if (do_commit_c) begin
                act_val_q <= shd_val_q;
                act_msk_q <= shd_msk_q;
                act_rld_q <= shd_rld_q;
            end
            update_q <= do_commit_c;
            wready_q <= (state_d == IDLE);
        end
    end

    assign bus.wready  = wready_q;
    assign cfg_enable  = enable_q;
    assign cfg_mat_val = act_val_q;
    assign cfg_mat_msk = act_msk_q;
    assign cfg_cnt_rld = act_rld_q;
    assign cfg_update  = update_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_trigger_cfg_slave.sv
// Directed bench for trigger_cfg_slave: vector table plus busy/pend, saturation and reset sequences.
module tb_trigger_cfg_slave;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         trg_busy = 1'b0;
    logic         cfg_enable;
    logic [127:0] cfg_mat_val, cfg_mat_msk, cfg_cnt_rld;
    logic         cfg_update;
    logic [7:0]   err_cnt;

    int checks = 0;
    int failures = 0;

    trigger_cfg_slave_if #(.BAW(8), .BDW(32)) bus ();

    trigger_cfg_slave #(
        .BAW(8), .BDW(32), .SDW(32), .TMN(4), .TCN(4), .TCW(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .trg_busy    (trg_busy),
        .cfg_enable  (cfg_enable),
        .cfg_mat_val (cfg_mat_val),
        .cfg_mat_msk (cfg_mat_msk),
        .cfg_cnt_rld (cfg_cnt_rld),
        .cfg_update  (cfg_update),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        en;
        logic [31:0] val0;
        logic [31:0] msk0;
        logic [31:0] rld0;
        logic [31:0] rld3;
        logic        upd;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One bus transfer; returns just after the transfer edge
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        for (int k = 0; k < 50 && !bus.wready; k++) @(negedge clk);
        if (!bus.wready) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout addr=%0h actual_wready=0 required_wready=1", a);
        end
        bus.wvalid = 1'b1;
        bus.waddr  = a;
        bus.wdata  = d;
        @(posedge clk);
        #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enable"}, 128'(cfg_enable), 128'd0);
        chk({tag, "_val"},    cfg_mat_val,       128'd0);
        chk({tag, "_msk"},    cfg_mat_msk,       128'd0);
        chk({tag, "_rld"},    cfg_cnt_rld,       128'd0);
        chk({tag, "_update"}, 128'(cfg_update),  128'd0);
        chk({tag, "_err"},    128'(err_cnt),     128'd0);
    endtask

    initial begin
        bus.wvalid = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;

        vecs[0]  = '{8'h04, 32'h76543210, 1'b0, 32'h0,        32'h0,      32'd0,   32'h0,        1'b0, 8'd0};
        vecs[1]  = '{8'h05, 32'h0000FFFF, 1'b0, 32'h0,        32'h0,      32'd0,   32'h0,        1'b0, 8'd0};
        vecs[2]  = '{8'h00, 32'h00000003, 1'b1, 32'h76543210, 32'hFFFF,   32'd0,   32'h0,        1'b1, 8'd0};
        vecs[3]  = '{8'h0C, 32'd100,      1'b1, 32'h76543210, 32'hFFFF,   32'd0,   32'h0,        1'b0, 8'd0};
        vecs[4]  = '{8'h00, 32'h00000003, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h0,        1'b1, 8'd0};
        vecs[5]  = '{8'h00, 32'h00000003, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h0,        1'b1, 8'd0};
        vecs[6]  = '{8'hF0, 32'hDEADBEEF, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h0,        1'b0, 8'd1};
        vecs[7]  = '{8'hF0, 32'hDEADBEEF, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h0,        1'b0, 8'd2};
        vecs[8]  = '{8'hF0, 32'hDEADBEEF, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h0,        1'b0, 8'd3};
        vecs[9]  = '{8'h01, 32'h00000003, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h0,        1'b0, 8'd4};
        vecs[10] = '{8'h0F, 32'h12345678, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h0,        1'b0, 8'd4};
        vecs[11] = '{8'h00, 32'h00000001, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h0,        1'b0, 8'd4};
        vecs[12] = '{8'h00, 32'h00000002, 1'b0, 32'h76543210, 32'hFFFF,   32'd100, 32'h12345678, 1'b1, 8'd4};
        vecs[13] = '{8'h10, 32'hFFFFFFFF, 1'b0, 32'h76543210, 32'hFFFF,   32'd100, 32'h12345678, 1'b0, 8'd5};
        vecs[14] = '{8'h00, 32'h00000003, 1'b1, 32'h76543210, 32'hFFFF,   32'd100, 32'h12345678, 1'b1, 8'd5};

        // Reset and release
        repeat (2) @(negedge clk);
        chk("rst_wready", 128'(bus.wready), 128'd0);
        chk_all_zero("rst");
        rst = 1'b1;
        #1;
        chk("rel_wready_early", 128'(bus.wready), 128'd0);
        @(negedge clk);
        chk("rel_wready", 128'(bus.wready), 128'd1);

        // Table-driven writes with idle trigger core
        for (int v = 0; v < 15; v++) begin
            wr(vecs[v].addr, vecs[v].data);
            @(negedge clk);
            chk($sformatf("v%0d_enable", v), 128'(cfg_enable),          128'(vecs[v].en));
            chk($sformatf("v%0d_val0", v),   128'(cfg_mat_val[31:0]),   128'(vecs[v].val0));
            chk($sformatf("v%0d_msk0", v),   128'(cfg_mat_msk[31:0]),   128'(vecs[v].msk0));
            chk($sformatf("v%0d_rld0", v),   128'(cfg_cnt_rld[31:0]),   128'(vecs[v].rld0));
            chk($sformatf("v%0d_rld3", v),   128'(cfg_cnt_rld[127:96]), 128'(vecs[v].rld3));
            chk($sformatf("v%0d_update", v), 128'(cfg_update),          128'(vecs[v].upd));
            chk($sformatf("v%0d_err", v),    128'(err_cnt),             128'(vecs[v].err));
            chk($sformatf("v%0d_wready", v), 128'(bus.wready),          128'd1);
            @(negedge clk);
            chk($sformatf("v%0d_upd_fall", v), 128'(cfg_update), 128'd0);
        end

        // Commit deferred while busy; enable still updates immediately
        @(negedge clk);
        trg_busy = 1'b1;
        wr(8'h0C, 32'd200);
        wr(8'h00, 32'h00000002);
        @(negedge clk);
        chk("pend_wready", 128'(bus.wready), 128'd0);
        chk("pend_enable", 128'(cfg_enable), 128'd0);
        chk("pend_update", 128'(cfg_update), 128'd0);
        chk("pend_rld0",   128'(cfg_cnt_rld[31:0]), 128'd100);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("pend%0d_wready", c), 128'(bus.wready), 128'd0);
            chk($sformatf("pend%0d_rld0", c),   128'(cfg_cnt_rld[31:0]), 128'd100);
            chk($sformatf("pend%0d_update", c), 128'(cfg_update), 128'd0);
        end
        trg_busy = 1'b0;
        @(negedge clk);
        chk("unpend_rld0",   128'(cfg_cnt_rld[31:0]), 128'd200);
        chk("unpend_update", 128'(cfg_update), 128'd1);
        chk("unpend_wready", 128'(bus.wready), 128'd1);
        chk("unpend_enable", 128'(cfg_enable), 128'd0);
        @(negedge clk);
        chk("unpend_upd_fall", 128'(cfg_update), 128'd0);

        // Error counter saturation
        for (int n = 0; n < 300; n++) wr(8'hF0, 32'h0);
        @(negedge clk);
        chk("sat_err",  128'(err_cnt), 128'd255);
        chk("sat_rld0", 128'(cfg_cnt_rld[31:0]), 128'd200);
        chk("sat_val0", 128'(cfg_mat_val[31:0]), 128'h76543210);

        // Reset while a commit is pending
        trg_busy = 1'b1;
        wr(8'h0C, 32'd55);
        wr(8'h00, 32'h00000003);
        @(negedge clk);
        chk("rp_pend_wready", 128'(bus.wready), 128'd0);
        rst = 1'b0;
        #1;
        chk("rp_wready", 128'(bus.wready), 128'd0);
        chk_all_zero("rp");
        @(negedge clk);
        rst = 1'b1;
        trg_busy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rp%0d_update", c), 128'(cfg_update), 128'd0);
            chk($sformatf("rp%0d_rld",    c), cfg_cnt_rld,       128'd0);
            chk($sformatf("rp%0d_wready", c), 128'(bus.wready), 128'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
